rsbus_d2r_injector: RTL and testbench
=====================================

RSBUS_D2R_INJECTOR -- requirements
Module: rsbus_d2r_injector

Interface
REQ-001 SHALL have parameter PKT_LONG_WORDS, default 9, the word count of a long frame (header + 8 data); a short frame is 1 word.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 d2r_i_sof  input  1  first word of a ring slot.
REQ-005 d2r_i_ctrl  input  12  slot control word, valid with d2r_i_sof.
REQ-006 d2r_i_bus  input  72  slot word; header bit71 = stb (occupied), bit39 = len (1 = long).
REQ-007 d2r_o_sof / d2r_o_ctrl / d2r_o_bus  output  1/12/72  ring outputs to the next stage.
REQ-008 loc_wr  input  1  local packet word strobe.
REQ-009 loc_sof  input  1  marks a header word on the local port.
REQ-010 loc_bus  input  72  local packet word.
REQ-011 loc_ctrl  input  12  control word to emit with the header, sampled with loc_sof.
REQ-012 loc_rdy  output  1  buffer can accept words.
REQ-013 pkt_sent  output  1  one-cycle pulse when a packet has been inserted.

Function
REQ-014 Ring path SHALL have exactly 1 cycle latency: d2r_o_* equals d2r_i_* from the previous cycle except in words replaced per REQ-020.
REQ-015 State machine SHALL have the states IDLE, LOAD, ARMED and SEND.
REQ-016 IDLE: loc_rdy=1; loc_wr&&loc_sof stores word 0, latches loc_ctrl and len (loc_bus[39]); go to LOAD if len=1, otherwise go to ARMED.
REQ-017 LOAD: loc_rdy=1; each loc_wr stores the next word at a 4-bit write index; after word PKT_LONG_WORDS-1 go to ARMED.
REQ-018 LOAD: loc_wr&&loc_sof restarts the load (new word 0, index reset); loc_wr without loc_sof in IDLE SHALL be ignored.
REQ-019 ARMED: loc_rdy=0; on d2r_i_sof with d2r_i_bus[71]=0 and d2r_i_bus[39]=buffered len, go to SEND starting with word 0; occupied or length-mismatched slots pass unchanged.
REQ-020 SEND: slot word k is replaced by buffer word k (header forced bit71=1, bit70=0); d2r_o_ctrl = latched loc_ctrl on the header cycle; d2r_o_sof is unaffected.
REQ-021 Slot word counter SHALL reset on each d2r_i_sof; SEND SHALL end after 1 or PKT_LONG_WORDS words, then pkt_sent=1 for one cycle and return to IDLE.
REQ-022 d2r_i_sof inside SEND before the frame completes (malformed ring) SHALL abort the send, pass that slot through, return to ARMED and keep the packet.
REQ-023 Matching header word and last local word in the same cycle: the slot SHALL NOT be taken; the earliest usable slot is the next sof.
REQ-024 The buffer SHALL hold one packet; there is no back-to-back load during SEND (loc_rdy=0 in ARMED and SEND).

Reset
REQ-025 On rst: state=IDLE; d2r_o_sof=0, d2r_o_bus[71:70]=0, d2r_o_ctrl[11]=0, pkt_sent=0, loc_rdy=1 (after release); indices cleared.
REQ-026 Reset mid-SEND SHALL discard the packet; the remaining data bits need not be cleared; after release the ring passes through unchanged.
REQ-027 Buffer contents and ring data bits [69:0] need no reset.

Structure
REQ-028 The following SHALL live in rbus_pkg: header bit positions (STB=71, RECO=70, LEN=39), short/long word counts and the state enum.
REQ-029 The 16x72 packet buffer SHALL be the sub-module rsbus_pkt_buf (1 write port, 1 async read port).

Verification
REQ-030 Short local packet, ring carries an empty short slot: header emitted 1 cycle later with bit71=1 and ctrl=loc_ctrl, then pkt_sent pulses and loc_rdy returns to 1.
REQ-031 Long packet (9 words), ring carries an occupied long slot, then an empty short slot, then an empty long slot: the first two pass unchanged and words 0..8 appear in the third.
REQ-032 Restart during LOAD (loc_sof after 4 words): only the second packet is sent.
REQ-033 Assert rst during SEND word 3: outputs show the header bits cleared, then pass-through, and no pkt_sent.
REQ-034 Second d2r_i_sof at word 5 of a long SEND: send aborts, the packet is retried in the next empty long slot and pkt_sent pulses exactly once.
REQ-035 Idle ring with no local traffic for 1000 cycles: d2r_o equals d2r_i delayed exactly 1 cycle.

Source files
------------

// File: rtl/rbus_pkg.sv
// Shared ring-bus constants: frame geometry, header bit positions and the injector state encoding.
package rbus_pkg;

    localparam int BUS_W       = 72;
    localparam int CTRL_W      = 12;
    localparam int BUF_AW      = 4;

    localparam int STB_BIT     = 71;
    localparam int RECO_BIT    = 70;
    localparam int LEN_BIT     = 39;

    localparam int SHORT_WORDS = 1;
    localparam int LONG_WORDS  = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED,
        ST_SEND
    } inj_state_e;

endpackage

// File: rtl/rsbus_d2r_injector_if.sv
// Ring-slot and local-packet signals of the d2r injector; the master side drives the ring and local inputs.
interface rsbus_d2r_injector_if;
    import rbus_pkg::*;

    logic              d2r_i_sof;
    logic [CTRL_W-1:0] d2r_i_ctrl;
    logic [BUS_W-1:0]  d2r_i_bus;
    logic              d2r_o_sof;
    logic [CTRL_W-1:0] d2r_o_ctrl;
    logic [BUS_W-1:0]  d2r_o_bus;
    logic              loc_wr;
    logic              loc_sof;
    logic [BUS_W-1:0]  loc_bus;
    logic [CTRL_W-1:0] loc_ctrl;
    logic              loc_rdy;
    logic              pkt_sent;

    modport master (
        output d2r_i_sof, d2r_i_ctrl, d2r_i_bus, loc_wr, loc_sof, loc_bus, loc_ctrl,
        input  d2r_o_sof, d2r_o_ctrl, d2r_o_bus, loc_rdy, pkt_sent
    );

    modport slave (
        input  d2r_i_sof, d2r_i_ctrl, d2r_i_bus, loc_wr, loc_sof, loc_bus, loc_ctrl,
        output d2r_o_sof, d2r_o_ctrl, d2r_o_bus, loc_rdy, pkt_sent
    );

endinterface

// File: rtl/rsbus_pkt_buf.sv
// Single-packet word store: one synchronous write port, one asynchronous read port, no reset.
module rsbus_pkt_buf #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 72
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rsbus_d2r_injector.sv
// Inserts one buffered local packet into the first empty ring slot of matching length; ring latency is 1 cycle.
//   state | meaning
//   IDLE  | buffer empty, waiting for a local header word
//   LOAD  | collecting the remaining words of a long packet
//   ARMED | packet complete, waiting for an empty slot of the same length
//   SEND  | replacing slot words with buffer words
module rsbus_d2r_injector
    import rbus_pkg::*;
#(
    parameter int PKT_LONG_WORDS = LONG_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    rsbus_d2r_injector_if.slave  rs
);

    localparam logic [BUF_AW-1:0] LONG_LAST  = BUF_AW'(PKT_LONG_WORDS - 1);
    localparam logic [BUF_AW-1:0] SHORT_LAST = BUF_AW'(SHORT_WORDS - 1);

    inj_state_e        state_q, state_d;
    logic [BUF_AW-1:0] wr_idx_q, wr_idx_d, waddr, slot_cnt_q, cur_word, frame_last;
    logic              len_q, hdr_latch, wr_en, take, done;
    logic [CTRL_W-1:0] ctrl_q;
    logic [BUS_W-1:0]  rd_data;

    logic              o_sof_q, o_sof_d, pkt_sent_q;
    logic [CTRL_W-1:0] o_ctrl_q, o_ctrl_d;
    logic [BUS_W-1:0]  o_bus_q, o_bus_d;

    rsbus_pkt_buf #(.ADDR_W(BUF_AW), .WIDTH(BUS_W)) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (rs.loc_bus),
        .raddr (cur_word),
        .rdata (rd_data)
    );

    assign cur_word   = rs.d2r_i_sof ? '0 : slot_cnt_q;
    assign frame_last = len_q ? LONG_LAST : SHORT_LAST;

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        waddr     = wr_idx_q;
        wr_en     = 1'b0;
        hdr_latch = 1'b0;
        take      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (rs.loc_wr && rs.loc_sof) begin
                    wr_en     = 1'b1;
                    waddr     = '0;
                    wr_idx_d  = BUF_AW'(1);
                    hdr_latch = 1'b1;
                    state_d   = rs.loc_bus[LEN_BIT] ? ST_LOAD : ST_ARMED;
                end else if (rs.loc_wr && state_q == ST_LOAD) begin
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + BUF_AW'(1);
                    if (wr_idx_q == LONG_LAST) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rs.d2r_i_sof && !rs.d2r_i_bus[STB_BIT] && rs.d2r_i_bus[LEN_BIT] == len_q) begin
                    take    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // A short frame was fully replaced on entry, so any sof seen here is a fresh slot.
                if (slot_cnt_q > frame_last) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (rs.d2r_i_sof) begin
                    state_d = ST_ARMED;
                end else begin
                    take = 1'b1;
                    if (slot_cnt_q == frame_last) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_sof_d  = rs.d2r_i_sof;
        o_ctrl_d = rs.d2r_i_ctrl;
        o_bus_d  = rs.d2r_i_bus;
        if (take) begin
            o_bus_d = rd_data;
            if (cur_word == '0) begin
                o_bus_d[STB_BIT]  = 1'b1;
                o_bus_d[RECO_BIT] = 1'b0;
                o_ctrl_d          = ctrl_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_idx_q   <= '0;
            slot_cnt_q <= '0;
            len_q      <= 1'b0;
            ctrl_q     <= '0;
            o_sof_q    <= 1'b0;
            o_ctrl_q   <= '0;
            o_bus_q    <= '0;
            pkt_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            slot_cnt_q <= (cur_word == '1) ? cur_word : cur_word + BUF_AW'(1);
            if (hdr_latch) begin
                len_q  <= rs.loc_bus[LEN_BIT];
                ctrl_q <= rs.loc_ctrl;
            end
            o_sof_q    <= o_sof_d;
            o_ctrl_q   <= o_ctrl_d;
            o_bus_q    <= o_bus_d;
            pkt_sent_q <= done;
        end
    end

    assign rs.d2r_o_sof  = o_sof_q;
    assign rs.d2r_o_ctrl = o_ctrl_q;
    assign rs.d2r_o_bus  = o_bus_q;
    assign rs.pkt_sent   = pkt_sent_q;
    assign rs.loc_rdy    = (state_q == ST_IDLE) || (state_q == ST_LOAD);

endmodule

// File: tb/tb_rsbus_d2r_injector.sv
// Directed bench for the d2r injector: inputs change 1 ns after the rising edge, outputs are sampled there too.
module tb_rsbus_d2r_injector;
    import rbus_pkg::*;

    localparam int LW = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rsbus_d2r_injector_if rs ();

    rsbus_d2r_injector #(.PKT_LONG_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] lword(input int pkt, input int k, input logic len);
        logic [71:0] v;
        v = {4'h5, 4'(pkt), 8'(k), 56'h0123_4567_89AB_CD};
        if (k == 0) v[39] = len;
        return v;
    endfunction

    function automatic logic [71:0] rword(input int slot, input int k, input logic stb, input logic len);
        logic [71:0] v;
        v = {4'h6, 4'(slot), 8'(k), 56'hFEDC_BA98_7654_32};
        if (k == 0) begin
            v[71] = stb;
            v[39] = len;
        end
        return v;
    endfunction

    function automatic logic [71:0] hdr_exp(input int pkt, input logic len);
        logic [71:0] v;
        v = lword(pkt, 0, len);
        v[71] = 1'b1;
        v[70] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ring_in(input logic sof, input logic [11:0] ctrl, input logic [71:0] bus);
        rs.d2r_i_sof  = sof;
        rs.d2r_i_ctrl = ctrl;
        rs.d2r_i_bus  = bus;
        tick();
    endtask

    task automatic load_pkt(input int pkt, input logic len, input logic [11:0] ctrl, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            rs.loc_wr   = 1'b1;
            rs.loc_sof  = (k == 0);
            rs.loc_bus  = lword(pkt, k, len);
            rs.loc_ctrl = (k == 0) ? ctrl : 12'hFFF;
            tick();
        end
        rs.loc_wr  = 1'b0;
        rs.loc_sof = 1'b0;
        rs.loc_bus = '0;
    endtask

    task automatic test_reset();
        rs.d2r_i_sof = 1'b0; rs.d2r_i_ctrl = '0; rs.d2r_i_bus = '0;
        rs.loc_wr = 1'b0; rs.loc_sof = 1'b0; rs.loc_bus = '0; rs.loc_ctrl = '0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (rs.d2r_o_sof !== 1'b0 || rs.d2r_o_bus[71:70] !== 2'b00 || rs.d2r_o_ctrl[11] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ring: sof %b hdr %b ctrl11 %b, want 0 00 0",
                     rs.d2r_o_sof, rs.d2r_o_bus[71:70], rs.d2r_o_ctrl[11]);
        end
        checks++;
        if (rs.pkt_sent !== 1'b0) begin
            errors++;
            $display("FAIL reset_sent: got %b want 0", rs.pkt_sent);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (rs.loc_rdy !== 1'b1 || rs.pkt_sent !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy %b sent %b, want 1 0", rs.loc_rdy, rs.pkt_sent);
        end
    endtask

    task automatic test_short();
        load_pkt(1, 1'b0, 12'h5A5, 1);
        checks++;
        if (rs.loc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL short_armed_rdy: got %b want 0", rs.loc_rdy);
        end
        ring_in(1'b1, 12'h111, rword(1, 0, 1'b1, 1'b0));
        checks++;
        if (rs.d2r_o_bus !== rword(1, 0, 1'b1, 1'b0) || rs.d2r_o_ctrl !== 12'h111) begin
            errors++;
            $display("FAIL short_occupied_pass: bus %h ctrl %h, want %h 111",
                     rs.d2r_o_bus, rs.d2r_o_ctrl, rword(1, 0, 1'b1, 1'b0));
        end
        ring_in(1'b1, 12'h0F0, rword(2, 0, 1'b0, 1'b0));
        checks++;
        if (rs.d2r_o_sof !== 1'b1 || rs.d2r_o_bus !== hdr_exp(1, 1'b0) || rs.d2r_o_ctrl !== 12'h5A5
            || rs.pkt_sent !== 1'b0) begin
            errors++;
            $display("FAIL short_header: sof %b bus %h ctrl %h sent %b, want 1 %h 5a5 0",
                     rs.d2r_o_sof, rs.d2r_o_bus, rs.d2r_o_ctrl, rs.pkt_sent, hdr_exp(1, 1'b0));
        end
        ring_in(1'b0, 12'h222, rword(2, 1, 1'b0, 1'b0));
        checks++;
        if (rs.pkt_sent !== 1'b1 || rs.loc_rdy !== 1'b1 || rs.d2r_o_bus !== rword(2, 1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL short_done: sent %b rdy %b bus %h, want 1 1 %h",
                     rs.pkt_sent, rs.loc_rdy, rs.d2r_o_bus, rword(2, 1, 1'b0, 1'b0));
        end
        ring_in(1'b0, 12'h333, rword(2, 2, 1'b0, 1'b0));
        checks++;
        if (rs.pkt_sent !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse_width: sent %b want 0", rs.pkt_sent);
        end
    endtask

    task automatic test_long();
        logic [71:0] exp;
        for (int k = 0; k < LW; k++) begin
            rs.loc_wr = 1'b1; rs.loc_sof = (k == 0);
            rs.loc_bus = lword(2, k, 1'b1); rs.loc_ctrl = (k == 0) ? 12'h3C3 : 12'h000;
            tick();
            checks++;
            if (rs.loc_rdy !== (k < LW - 1)) begin
                errors++;
                $display("FAIL long_load_rdy[%0d]: got %b want %b", k, rs.loc_rdy, (k < LW - 1));
            end
        end
        rs.loc_wr = 1'b0; rs.loc_sof = 1'b0;
        for (int k = 0; k < LW; k++) begin
            ring_in(k == 0, 12'(16 + k), rword(3, k, 1'b1, 1'b1));
            checks++;
            if (rs.d2r_o_bus !== rword(3, k, 1'b1, 1'b1) || rs.d2r_o_ctrl !== 12'(16 + k) || rs.pkt_sent !== 1'b0) begin
                errors++;
                $display("FAIL long_occupied_pass[%0d]: bus %h ctrl %h sent %b", k, rs.d2r_o_bus, rs.d2r_o_ctrl, rs.pkt_sent);
            end
        end
        ring_in(1'b1, 12'h0AA, rword(4, 0, 1'b0, 1'b0));
        checks++;
        if (rs.d2r_o_bus !== rword(4, 0, 1'b0, 1'b0) || rs.d2r_o_ctrl !== 12'h0AA) begin
            errors++;
            $display("FAIL long_len_mismatch_pass: bus %h ctrl %h, want %h 0aa", rs.d2r_o_bus, rs.d2r_o_ctrl, rword(4, 0, 1'b0, 1'b0));
        end
        for (int k = 0; k < LW; k++) begin
            ring_in(k == 0, 12'(32 + k), rword(5, k, 1'b0, 1'b1));
            exp = (k == 0) ? hdr_exp(2, 1'b1) : lword(2, k, 1'b1);
            checks++;
            if (rs.d2r_o_bus !== exp || rs.d2r_o_ctrl !== ((k == 0) ? 12'h3C3 : 12'(32 + k))
                || rs.d2r_o_sof !== (k == 0) || rs.pkt_sent !== (k == LW - 1)) begin
                errors++;
                $display("FAIL long_insert[%0d]: bus %h ctrl %h sent %b, want bus %h sent %b",
                         k, rs.d2r_o_bus, rs.d2r_o_ctrl, rs.pkt_sent, exp, (k == LW - 1));
            end
        end
        ring_in(1'b0, 12'h000, rword(6, 1, 1'b0, 1'b0));
        checks++;
        if (rs.pkt_sent !== 1'b0 || rs.loc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL long_after: sent %b rdy %b, want 0 1", rs.pkt_sent, rs.loc_rdy);
        end
    endtask

    task automatic test_restart();
        logic [71:0] exp;
        load_pkt(3, 1'b1, 12'h111, 4);
        load_pkt(4, 1'b1, 12'h444, LW);
        checks++;
        if (rs.loc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL restart_armed: rdy %b want 0", rs.loc_rdy);
        end
        for (int k = 0; k < LW; k++) begin
            ring_in(k == 0, 12'h050, rword(7, k, 1'b0, 1'b1));
            exp = (k == 0) ? hdr_exp(4, 1'b1) : lword(4, k, 1'b1);
            checks++;
            if (rs.d2r_o_bus !== exp || rs.d2r_o_ctrl !== ((k == 0) ? 12'h444 : 12'h050) || rs.pkt_sent !== (k == LW - 1)) begin
                errors++;
                $display("FAIL restart_insert[%0d]: bus %h ctrl %h sent %b, want bus %h", k, rs.d2r_o_bus, rs.d2r_o_ctrl, rs.pkt_sent, exp);
            end
        end
    endtask

    task automatic test_same_cycle();
        rs.loc_wr = 1'b1; rs.loc_sof = 1'b1; rs.loc_bus = lword(5, 0, 1'b0); rs.loc_ctrl = 12'h5C5;
        ring_in(1'b1, 12'h077, rword(8, 0, 1'b0, 1'b0));
        rs.loc_wr = 1'b0; rs.loc_sof = 1'b0; rs.loc_bus = '0;
        checks++;
        if (rs.d2r_o_bus !== rword(8, 0, 1'b0, 1'b0) || rs.d2r_o_ctrl !== 12'h077 || rs.loc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pass: bus %h ctrl %h rdy %b, want %h 077 0", rs.d2r_o_bus, rs.d2r_o_ctrl, rs.loc_rdy, rword(8, 0, 1'b0, 1'b0));
        end
        ring_in(1'b1, 12'h078, rword(9, 0, 1'b0, 1'b0));
        checks++;
        if (rs.d2r_o_bus !== hdr_exp(5, 1'b0) || rs.d2r_o_ctrl !== 12'h5C5) begin
            errors++;
            $display("FAIL same_cycle_next: bus %h ctrl %h, want %h 5c5", rs.d2r_o_bus, rs.d2r_o_ctrl, hdr_exp(5, 1'b0));
        end
        ring_in(1'b0, 12'h000, rword(9, 1, 1'b0, 1'b0));
        checks++;
        if (rs.pkt_sent !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_sent: got %b want 1", rs.pkt_sent);
        end
    endtask

    task automatic test_abort();
        logic [71:0] exp;
        logic        take;
        int          sent_cnt;
        sent_cnt = 0;
        load_pkt(7, 1'b1, 12'h777, LW);
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < LW; k++) begin
                if (s == 0 && k == 5) break;
                ring_in(k == 0, 12'(k), rword(10 + s, k, 1'b0, 1'b1));
                take = (s == 0) || (s == 2);
                exp  = !take ? rword(10 + s, k, 1'b0, 1'b1) : (k == 0) ? hdr_exp(7, 1'b1) : lword(7, k, 1'b1);
                if (rs.pkt_sent === 1'b1) sent_cnt++;
                checks++;
                if (rs.d2r_o_bus !== exp || rs.d2r_o_ctrl !== ((take && k == 0) ? 12'h777 : 12'(k))) begin
                    errors++;
                    $display("FAIL abort_slot%0d[%0d]: bus %h ctrl %h, want %h", s, k, rs.d2r_o_bus, rs.d2r_o_ctrl, exp);
                end
            end
        end
        ring_in(1'b0, 12'h000, rword(13, 1, 1'b0, 1'b0));
        if (rs.pkt_sent === 1'b1) sent_cnt++;
        checks++;
        if (sent_cnt != 1) begin
            errors++;
            $display("FAIL abort_sent_count: got %0d want 1", sent_cnt);
        end
    endtask

    task automatic test_rst_send();
        logic [71:0] exp;
        load_pkt(6, 1'b1, 12'h666, LW);
        for (int k = 0; k < 3; k++) begin
            ring_in(k == 0, 12'h800, rword(14, k, 1'b0, 1'b1));
            exp = (k == 0) ? hdr_exp(6, 1'b1) : lword(6, k, 1'b1);
            checks++;
            if (rs.d2r_o_bus !== exp) begin
                errors++;
                $display("FAIL rst_send_pre[%0d]: bus %h want %h", k, rs.d2r_o_bus, exp);
            end
        end
        rs.d2r_i_sof = 1'b0; rs.d2r_i_ctrl = 12'h800; rs.d2r_i_bus = rword(14, 3, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (rs.d2r_o_sof !== 1'b0 || rs.d2r_o_bus[71:70] !== 2'b00 || rs.d2r_o_ctrl[11] !== 1'b0 || rs.pkt_sent !== 1'b0) begin
            errors++;
            $display("FAIL rst_send_clear: sof %b hdr %b ctrl11 %b sent %b, want 0 00 0 0",
                     rs.d2r_o_sof, rs.d2r_o_bus[71:70], rs.d2r_o_ctrl[11], rs.pkt_sent);
        end
        tick();
        rst = 1'b0;
        for (int k = 4; k < LW; k++) begin
            ring_in(1'b0, 12'h800, rword(14, k, 1'b0, 1'b1));
            checks++;
            if (rs.d2r_o_bus !== rword(14, k, 1'b0, 1'b1) || rs.d2r_o_ctrl !== 12'h800 || rs.pkt_sent !== 1'b0
                || rs.loc_rdy !== 1'b1) begin
                errors++;
                $display("FAIL rst_send_post[%0d]: bus %h ctrl %h sent %b rdy %b", k, rs.d2r_o_bus, rs.d2r_o_ctrl, rs.pkt_sent, rs.loc_rdy);
            end
        end
    endtask

    task automatic test_idle_ring();
        logic [95:0] r;
        logic        sof;
        logic [11:0] ctrl;
        for (int i = 0; i < 1000; i++) begin
            r    = {$urandom, $urandom, $urandom};
            sof  = ($urandom_range(0, 3) == 0);
            ctrl = 12'($urandom);
            ring_in(sof, ctrl, r[71:0]);
            checks++;
            if (rs.d2r_o_sof !== sof || rs.d2r_o_ctrl !== ctrl || rs.d2r_o_bus !== r[71:0] || rs.pkt_sent !== 1'b0) begin
                errors++;
                $display("FAIL idle_pass[%0d]: sof %b ctrl %h bus %h, want %b %h %h", i, rs.d2r_o_sof, rs.d2r_o_ctrl, rs.d2r_o_bus, sof, ctrl, r[71:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_restart();
        test_same_cycle();
        test_abort();
        test_rst_send();
        test_idle_ring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
